// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator: decodes and extends the immediate,
// then delivers it through a valid/ready stage with an optional 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1,
  localparam int unsigned INSTR_W = 32,
  localparam int unsigned FMT_W   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [FMT_W-1:0]   in_fmt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [FMT_W-1:0]   out_fmt,
  output logic               out_illegal
);

  localparam logic [FMT_W-1:0] FMT_I     = 3'd0;
  localparam logic [FMT_W-1:0] FMT_S     = 3'd1;
  localparam logic [FMT_W-1:0] FMT_B     = 3'd2;
  localparam logic [FMT_W-1:0] FMT_J     = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U     = 3'd4;
  localparam logic [FMT_W-1:0] FMT_SHAMT = 3'd5;
  localparam logic [FMT_W-1:0] FMT_ZIMM  = 3'd6;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_bad
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Decode into a 32-bit value, then sign- or zero-extend through a 64-bit view.
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic        zext;
  logic        illegal;
  entry_t      dec;

  always_comb begin
    imm32   = '0;
    zext    = 1'b0;
    illegal = 1'b0;
    case (in_fmt)
      FMT_I: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B: imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                      in_instr[11:8], 1'b0};
      FMT_J: imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                      in_instr[30:21], 1'b0};
      FMT_U: imm32 = {in_instr[31:12], 12'h000};
      FMT_SHAMT: begin
        zext = 1'b1;
        if (XLEN == 64) begin
          imm32 = {26'd0, in_instr[25:20]};
        end else begin
          imm32   = {27'd0, in_instr[24:20]};
          illegal = in_instr[25];
        end
      end
      FMT_ZIMM: begin
        zext  = 1'b1;
        imm32 = {27'd0, in_instr[19:15]};
      end
      default: begin
        zext    = 1'b1;
        illegal = 1'b1;
      end
    endcase
    imm64       = zext ? {32'd0, imm32} : {{32{imm32[31]}}, imm32};
    dec.imm     = imm64[XLEN-1:0];
    dec.fmt     = in_fmt;
    dec.illegal = illegal;
  end

  // Opcode bits and the upper half of the 64-bit view (XLEN=32) carry no immediate.
  logic unused_bits;
  assign unused_bits = ^{in_instr[6:0], imm64};

  if (SKID_EN) begin : g_skid
    state_e state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    logic   accept;
    logic   drain;

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_EMPTY;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !drain) state_d = ST_FULL;
          else if (!accept && drain) state_d = ST_EMPTY;
        end
        ST_FULL: if (drain) state_d = ST_ONE;
        default: state_d = ST_EMPTY;
      endcase
    end

    // Data movement; handshake flags are registered from the next state so
    // in_ready has no combinational path from out_ready.
    always_comb begin
      out_d  = out_q;
      skid_d = skid_q;
      case (state_q)
        ST_EMPTY: if (accept) out_d = dec;
        ST_ONE: begin
          if (accept && drain) out_d = dec;
          else if (accept) skid_d = dec;
        end
        ST_FULL: if (drain) out_d = skid_q;
        default: ;
      endcase
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q       <= '0;
        skid_q      <= '0;
        in_ready_q  <= 1'b1;
        out_valid_q <= 1'b0;
      end else begin
        out_q       <= out_d;
        skid_q      <= skid_d;
        in_ready_q  <= in_ready_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
  end else begin : g_single
    entry_t out_q, out_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_c;
    logic   accept;
    logic   drain;

    assign in_ready_c = ~out_valid_q | out_ready;
    assign accept     = in_valid & in_ready_c;
    assign drain      = out_valid_q & out_ready;

    always_comb begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else if (drain) begin
        out_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_q       <= out_d;
        out_valid_q <= out_valid_d;
      end
    end

    assign in_ready    = in_ready_c;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_illegal = out_q.illegal;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream
// and are scored against a queue-based reference built from the decode rules.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_fmt;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;
  int n_acc    = 0;
  int n_drn    = 0;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  fmt;
  } txn_t;
  txn_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_fmt(in_fmt), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
  );

  // Immediate as a signed integer per format, truncated to xlen.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] f,
                                          input int xlen);
    longint v;
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    logic signed [31:0] s32;
    case (f)
      3'd0: begin s12 = i[31:20]; v = s12; end
      3'd1: begin s12 = {i[31:25], i[11:7]}; v = s12; end
      3'd2: begin s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = s13; end
      3'd3: begin s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = s21; end
      3'd4: begin s32 = {i[31:12], 12'h000}; v = s32; end
      3'd5: if (xlen == 64) v = longint'(i[25:20]); else v = longint'(i[24:20]);
      3'd6: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  function automatic logic ref_ill(input logic [31:0] i, input logic [2:0] f, input int xlen);
    return (f == 3'd7) || (f == 3'd5 && xlen == 32 && i[25]);
  endfunction

  // Occupancy model: at most two entries in flight, FIFO order.
  always @(posedge clk) begin
    bit dr, ac;
    if (rst) begin
      q.delete();
    end else begin
      dr = (q.size() > 0) && out_ready;
      ac = in_valid && (q.size() < 2);
      if (dr) begin
        void'(q.pop_front());
        n_drn++;
      end
      if (ac) begin
        q.push_back('{instr: in_instr, fmt: in_fmt});
        n_acc++;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e32, e64;
    if (mon_en) begin
      checks++;
      if (out_valid32 !== 1'(q.size() > 0) || out_valid64 !== 1'(q.size() > 0)) begin
        failures++;
        $display("FAIL mon_out_valid got32=%0b got64=%0b exp=%0b", out_valid32, out_valid64, q.size() > 0);
      end
      checks++;
      if (in_ready32 !== 1'(q.size() < 2) || in_ready64 !== 1'(q.size() < 2)) begin
        failures++;
        $display("FAIL mon_in_ready got32=%0b got64=%0b exp=%0b", in_ready32, in_ready64, q.size() < 2);
      end
      if (q.size() > 0) begin
        e32 = ref_imm(q[0].instr, q[0].fmt, 32);
        e64 = ref_imm(q[0].instr, q[0].fmt, 64);
        checks++;
        if (imm32 !== e32[31:0] || fmt32 !== q[0].fmt || ill32 !== ref_ill(q[0].instr, q[0].fmt, 32)) begin
          failures++;
          $display("FAIL mon_head32 instr=%h fmt=%0d got imm=%h fmt=%0d ill=%0b exp imm=%h ill=%0b",
                   q[0].instr, q[0].fmt, imm32, fmt32, ill32, e32[31:0], ref_ill(q[0].instr, q[0].fmt, 32));
        end
        checks++;
        if (imm64 !== e64 || fmt64 !== q[0].fmt || ill64 !== ref_ill(q[0].instr, q[0].fmt, 64)) begin
          failures++;
          $display("FAIL mon_head64 instr=%h fmt=%0d got imm=%h fmt=%0d ill=%0b exp imm=%h ill=%0b",
                   q[0].instr, q[0].fmt, imm64, fmt64, ill64, e64, ref_ill(q[0].instr, q[0].fmt, 64));
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0; in_fmt = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'd0 || fmt32 !== 3'd0 || ill32 !== 1'b0) begin
      failures++;
      $display("FAIL reset32 got valid=%0b ready=%0b imm=%h fmt=%0d ill=%0b exp 0 1 0 0 0",
               out_valid32, in_ready32, imm32, fmt32, ill32);
    end
    checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || imm64 !== 64'd0 || fmt64 !== 3'd0 || ill64 !== 1'b0) begin
      failures++;
      $display("FAIL reset64 got valid=%0b ready=%0b imm=%h fmt=%0d ill=%0b exp 0 1 0 0 0",
               out_valid64, in_ready64, imm64, fmt64, ill64);
    end
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ti [8] = '{32'hFFF00093, 32'hFE000EE3, 32'h0000006F, 32'h800002B7,
                            32'h03F01013, 32'hFFFFFFFF, 32'h000F8073, 32'hFE112C23};
    logic [2:0]  tf [8] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd6, 3'd1};
    logic [31:0] e32 [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0, 32'h80000000,
                             32'h1F, 32'h0, 32'h1F, 32'hFFFFFFF8};
    logic        i32 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [63:0] e64 [8] = '{64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFC, 64'h0,
                             64'hFFFFFFFF_80000000, 64'h3F, 64'h0, 64'h1F,
                             64'hFFFFFFFF_FFFFFFF8};
    logic        i64 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      in_instr = ti[k]; in_fmt = tf[k]; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_valid32 !== 1'b1 || imm32 !== e32[k] || ill32 !== i32[k] || fmt32 !== tf[k]) begin
        failures++;
        $display("FAIL directed32[%0d] got v=%0b imm=%h ill=%0b fmt=%0d exp v=1 imm=%h ill=%0b fmt=%0d",
                 k, out_valid32, imm32, ill32, fmt32, e32[k], i32[k], tf[k]);
      end
      checks++;
      if (out_valid64 !== 1'b1 || imm64 !== e64[k] || ill64 !== i64[k] || fmt64 !== tf[k]) begin
        failures++;
        $display("FAIL directed64[%0d] got v=%0b imm=%h ill=%0b fmt=%0d exp v=1 imm=%h ill=%0b fmt=%0d",
                 k, out_valid64, imm64, ill64, fmt64, e64[k], i64[k], tf[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] it [4];
    logic [2:0]  ft [4];
    logic [63:0] e;
    logic [31:0] held = '0;
    bit          stalled = 1'b0;
    int          a0 = n_acc;
    int          got = 0;
    for (int i = 0; i < 4; i++) begin
      it[i] = $urandom;
      ft[i] = 3'($urandom_range(0, 6));
    end
    for (int c = 0; c < 40 && got < 4; c++) begin
      int k = n_acc - a0;
      in_valid = (k < 4);
      if (k < 4) begin in_instr = it[k]; in_fmt = ft[k]; end
      out_ready = (c >= 3);
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (in_ready32 !== 1'b0 || (n_acc - a0) != 2) begin
          failures++;
          $display("FAIL bp_full got in_ready=%0b accepted=%0d exp in_ready=0 accepted=2",
                   in_ready32, n_acc - a0);
        end
      end
      if (out_valid32 && !out_ready) begin
        if (stalled) begin
          checks++;
          if (imm32 !== held) begin
            failures++;
            $display("FAIL bp_stable got imm=%h exp imm=%h", imm32, held);
          end
        end
        held = imm32; stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid32 && out_ready) begin
        e = ref_imm(it[got], ft[got], 32);
        checks++;
        if (imm32 !== e[31:0] || fmt32 !== ft[got]) begin
          failures++;
          $display("FAIL bp_order[%0d] got imm=%h fmt=%0d exp imm=%h fmt=%0d",
                   got, imm32, fmt32, e[31:0], ft[got]);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL bp_count got outputs=%0d exp outputs=4", got);
    end
  endtask

  task automatic test_random();
    int a0 = n_acc;
    int d0 = n_drn;
    for (int c = 0; c < 500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_instr  = $urandom;
      in_fmt    = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ((n_acc - a0) != (n_drn - d0) || (n_acc - a0) < 50) begin
      failures++;
      $display("FAIL rand_conserve got accepted=%0d drained=%0d exp equal and >=50",
               n_acc - a0, n_drn - d0);
    end
  endtask

  task automatic test_reset_full();
    logic [63:0] e;
    out_ready = 1'b0; in_valid = 1'b1;
    in_instr = $urandom; in_fmt = 3'd0;
    @(posedge clk); #1;
    in_instr = $urandom; in_fmt = 3'd4;
    @(posedge clk); #1;
    checks++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1) begin
      failures++;
      $display("FAIL rstfull_pre got in_ready=%0b out_valid=%0b exp 0 1", in_ready32, out_valid32);
    end
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
      failures++;
      $display("FAIL rstfull_post got v32=%0b r32=%0b v64=%0b r64=%0b exp 0 1 0 1",
               out_valid32, in_ready32, out_valid64, in_ready64);
    end
    in_valid = 1'b1; in_instr = 32'h80000337; in_fmt = 3'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = ref_imm(32'h80000337, 3'd4, 64);
    checks++;
    if (out_valid64 !== 1'b1 || imm64 !== e) begin
      failures++;
      $display("FAIL rstfull_first got v=%0b imm=%h exp v=1 imm=%h", out_valid64, imm64, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_full();
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
